mult_operand_feeder: RTL and testbench
======================================

# mult_operand_feeder

Front-end stage that sits directly upstream of the 4x4 sequential add-shift multiplier. It accepts a stream of operand pairs over a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time to the multiplier with a start pulse. It then waits for the multiplier's done pulse, captures the 8-bit product and presents it downstream over a second valid/ready handshake. A watchdog flags a multiplier that never reports done.

## Interface
- DEPTH, 4, operand FIFO entries; power of 2, ≥2
- W, 4, operand width; product is 2·W
- TIMEOUT, 16, max cycles in WAIT before error; ≥2

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept (= !full)
- in_a, in_b  in  W  multiplicand, multiplier
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a, mul_b  out  W  operands to multiplier, stable from start through done
- mul_done  in  1  multiplier done pulse
- mul_product  in  2W  multiplier result, valid in the mul_done cycle
- out_valid  out  1  product held for downstream
- out_ready  in  1  downstream accepts
- out_product  out  2W  captured product
- busy  out  1  FSM not in IDLE or FIFO non-empty
- err  out  1  sticky timeout flag, cleared only by rst

## Operation
- Push occurs when in_valid && in_ready. Pop occurs only on the IDLE→ISSUE transition.
- When full, a push is refused even if a pop happens in the same cycle. in_ready is a function of registered count only.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into mul_a/mul_b registers and go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle, clear the watchdog, go to WAIT.
  - WAIT: on mul_done, capture mul_product into out_product and go to HOLD. If the watchdog reaches TIMEOUT-1 without done, set err, drop the operation (no output) and go to IDLE.
  - HOLD: out_valid=1. On out_ready, go to IDLE.
- mul_done in any state other than WAIT is ignored.
- mul_a/mul_b hold their value until the next pop.
- Product is not checked. Width is exactly 2W, no truncation.
- Reset values:
  - state=IDLE
  - FIFO count, rd_ptr, wr_ptr = 0
  - mul_start=0, mul_a=mul_b=0
  - out_valid=0, out_product=0
  - err=0, busy=0
  - in_ready=1 in the cycle after reset
- Reset mid-operation (any state) discards FIFO contents and any in-flight or held product. A later stray mul_done is ignored because the FSM is in IDLE.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits so full and empty are distinguished.

## Timing
- Push at edge t. IDLE sees non-empty in cycle t+1; the pop happens at edge t+1. mul_start is high in cycle t+2.
- Input-to-start latency is 2 cycles with the FSM idle. Start-to-output is the multiplier latency plus 1 (capture edge).
- out_valid rises the cycle after mul_done. It stays high with out_product stable until out_ready is sampled high.
- Back-to-back: minimum 4 cycles between consecutive mul_start pulses (IDLE, ISSUE, WAIT ≥1, HOLD ≥1).
- Back-pressure: out_ready low holds HOLD indefinitely. No new mul_start is issued meanwhile. The FIFO keeps accepting until full.
- err rises in the cycle after the TIMEOUT-th WAIT cycle.

## Structure
- Package mult_feeder_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, HOLD)
  - default W, DEPTH and TIMEOUT constants
  - the product width function 2·W
- Sub-module operand_fifo (parameters DEPTH, 2W data) provides push/pop, full/empty and count. The top holds the FSM, operand and product registers, and the watchdog counter.

## Test plan
- Reset, then push a=3, b=5. Expect mul_start 2 cycles after the push with mul_a=3, mul_b=5. Model done after 6 cycles with 0x0F. Expect out_valid with out_product=0x0F; with out_ready=1, out_valid drops the next cycle.
- Push 15×15 → out_product=0xE1. Push 0×9 → 0x00. Check that the two products come out in order.
- Hold out_ready=0 and push 5 pairs: in_ready goes low after 4 buffered (first popped, then 4 more). The 5th+ push is refused until out_ready=1 frees entries. Only one mul_start is seen while stalled.
- Never assert mul_done: err=1 exactly 16 WAIT cycles after mul_start, no out_valid, and the FSM issues the next queued pair.
- Assert rst during WAIT with 2 queued pairs, then pulse mul_done: no out_valid, busy=0, in_ready=1, and no mul_start follows.
- Pulse mul_done while in IDLE and again in HOLD: no state change, out_product unchanged.

Source files
------------

// File: rtl/mult_feeder_pkg.sv
// Shared definitions for the multiplier operand feeder: state encoding,
// default sizing and the product width helper.
package mult_feeder_pkg;

  localparam int W_DEF       = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } feeder_state_e;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Circular operand buffer; count is one bit wider than the pointers so
// full and empty are distinct.
module operand_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/mult_operand_feeder.sv
// Buffers operand pairs, issues them one at a time to the add-shift
// multiplier, holds each product for downstream and watches for a stuck multiplier.
module mult_operand_feeder
  import mult_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic             mul_done,
  input  logic [2*W-1:0]   mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready depends only on
  // registered FIFO occupancy.

  localparam int PW = prod_width(W);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] HOLD  = ST_HOLD;

  logic [1:0]             state;
  logic [TW-1:0]          wd_cnt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [PW-1:0]          fifo_head;
  logic                   push;
  logic                   pop;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign mul_start = (state == ISSUE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign dbg_state = state;

  operand_fifo #(
    .DEPTH (DEPTH),
    .DW    (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mul_a       <= '0;
      mul_b       <= '0;
      out_product <= '0;
      err         <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mul_a <= fifo_head[PW-1:W];
            mul_b <= fifo_head[W-1:0];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still counts.
          if (mul_done) begin
            out_product <= mul_product;
            state       <= HOLD;
          end else if (wd_cnt == WD_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Directed bench for mult_operand_feeder with a transaction-level scoreboard
// and a behavioural multiplier responder.
module tb_mult_operand_feeder;
  import mult_feeder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic       mul_start;
  logic [3:0] mul_a, mul_b;
  logic       mul_done;
  logic [7:0] mul_product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  logic       resp_en;
  logic       resp_done;
  logic       stray_done;
  logic [7:0] resp_prod;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  logic [7:0] op_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign mul_done    = resp_done | stray_done;
  assign mul_product = resp_prod;

  mult_operand_feeder #(.DEPTH(4), .W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair until accepted; the model records it only on acceptance.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int k;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      in_valid = 1'b0;
      fail_now("push_timeout");
    end else begin
      tick();
      op_q.push_back({a, b});
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input logic [7:0] exp, input string name);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) fail_now({name, "_timeout"});
    else check(name, out_product, exp);
    tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || out_valid) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) fail_now("idle_timeout");
  endtask

  // Multiplier model: done pulse 6 cycles after start, product from its operands.
  initial begin
    int cd;
    cd = -1;
    resp_done = 1'b0;
    resp_prod = '0;
    forever begin
      tick();
      resp_done = 1'b0;
      if (rst) begin
        cd = -1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            resp_prod = {4'b0, mul_a} * {4'b0, mul_b};
            resp_done = 1'b1;
            cd = -1;
          end
        end
        if (mul_start && resp_en) cd = 6;
      end
    end
  end

  // Scoreboard: every cycle, compare outputs against the transaction model.
  initial begin
    int cyc;
    int last_start;
    logic prev_ov, prev_or, prev_err;
    logic [7:0] prev_prod, last_ops, exp_ops, pe;
    cyc = 0;
    last_start = -100;
    prev_ov = 0; prev_or = 0; prev_err = 0;
    prev_prod = '0; last_ops = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        op_q.delete();
        exp_q.delete();
        prev_ov = 0; prev_or = 0; prev_err = 0;
        last_start = -100;
      end else begin
        if (err && !prev_err) begin
          check("err_latency", cyc - last_start, 17);
          if (exp_q.size() == 0) fail_now("err_without_op");
          else void'(exp_q.pop_back());
        end
        if (prev_err) check("err_sticky", err, 1);
        check("busy", busy, (op_q.size() + exp_q.size()) != 0);
        if (exp_q.size() != 0 && !mul_start)
          check("mul_ops_stable", {mul_a, mul_b}, last_ops);
        if (prev_ov && !prev_or) begin
          check("out_hold_valid", out_valid, 1);
          check("out_hold_prod", out_product, prev_prod);
        end
        if (mul_start) begin
          check("start_spacing", (cyc - last_start) >= 4, 1);
          if (op_q.size() == 0) begin
            fail_now("start_without_op");
          end else begin
            exp_ops = op_q.pop_front();
            check("mul_ops", {mul_a, mul_b}, exp_ops);
            pe = {4'b0, exp_ops[7:4]} * {4'b0, exp_ops[3:0]};
            exp_q.push_back(pe);
          end
          last_start = cyc;
          last_ops = {mul_a, mul_b};
          start_cnt++;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("spurious_out_valid");
          end else begin
            check("out_product", out_product, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_err = err;
        prev_prod = out_product;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s0;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; resp_en = 1'b1; stray_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 8'h00);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);

    // Single operation: 3 x 5, latency checks.
    push(4'd3, 4'd5);
    check("t1_no_start_yet", mul_start, 0);
    tick();
    check("t1_start", mul_start, 1);
    check("t1_mul_a", mul_a, 4'd3);
    check("t1_mul_b", mul_b, 4'd5);
    repeat (6) tick();
    check("t1_valid_in_done_cycle", out_valid, 0);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_product", out_product, 8'h0F);
    out_ready = 1'b1;
    tick();
    check("t1_valid_drop", out_valid, 0);

    // Boundary operands, ordering.
    push(4'd15, 4'd15);
    push(4'd0, 4'd9);
    wait_out(8'hE1, "t2_first");
    wait_out(8'h00, "t2_second");
    wait_idle();

    // Back-pressure fills the FIFO behind a held product.
    out_ready = 1'b0;
    s0 = start_cnt;
    push(4'd1, 4'd2);
    push(4'd2, 4'd3);
    push(4'd3, 4'd4);
    push(4'd4, 4'd5);
    push(4'd5, 4'd6);
    check("t3_full", in_ready, 0);
    in_valid = 1'b1; in_a = 4'd6; in_b = 4'd7;
    for (int i = 0; i < 3; i++) begin
      check("t3_refused", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    check("t3_one_start", start_cnt - s0, 1);
    check("t3_held_valid", out_valid, 1);
    check("t3_held_product", out_product, 8'h02);
    out_ready = 1'b1;
    push(4'd6, 4'd7);
    wait_idle();
    check("t3_all_started", start_cnt - s0, 6);

    // Watchdog: first op never completes, second is issued afterwards.
    resp_en = 1'b0;
    push(4'd7, 4'd7);
    push(4'd2, 4'd9);
    k = 0;
    while (!err && k < 40) begin
      check("t4_no_out_valid", out_valid, 0);
      tick();
      k++;
    end
    check("t4_err_latency", k, 17);
    check("t4_err", err, 1);
    resp_en = 1'b1;
    wait_out(8'h12, "t4_next_product");
    wait_idle();

    // Reset in WAIT with two queued pairs, then a stray done.
    resp_en = 1'b0;
    s0 = start_cnt;
    push(4'd1, 4'd1);
    push(4'd2, 4'd2);
    push(4'd3, 4'd3);
    tick();
    check("t5_in_wait", dbg_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_err_cleared", err, 0);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_no_start", mul_start, 0);
      check("t5_no_out", out_valid, 0);
      tick();
    end
    resp_en = 1'b1;

    // Stray done in IDLE and in HOLD.
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("t6_idle_state", dbg_state, 0);
    check("t6_idle_out_valid", out_valid, 0);
    check("t6_idle_product", out_product, 8'h00);
    out_ready = 1'b0;
    push(4'd2, 4'd4);
    wait_out(8'h08, "t6_product");
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("t6_hold_state", dbg_state, 3);
    check("t6_hold_valid", out_valid, 1);
    check("t6_hold_product", out_product, 8'h08);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_released", out_valid, 0);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("t6_after_product", out_product, 8'h08);
    check("t6_after_state", dbg_state, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
